// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write arbiter.
package rf_arb_pkg;

  localparam int RF_W = 8;
  localparam int RF_D = 4;
  localparam int RF_N = 3;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_DBG  = 2;

  typedef enum logic {ARB_IDLE, ARB_PENDING} arb_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational winner selection among write requesters.
// RF_ARB_FIXED_PRIO_EN: lowest index always wins and ptr is ignored.
module rr_picker import rf_arb_pkg::*; #(
  parameter int N  = RF_N,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx
);

  int            cand;
  logic [IW-1:0] sel;
  logic          found;

`ifdef RF_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
`endif

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    sel    = '0;
    for (int i = 0; i < N; i++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
      cand = i;
`else
      // search begins at ptr and wraps past the top index
      cand = int'(ptr) + i;
      if (cand >= N) cand = cand - N;
`endif
      sel = IW'(cand);
      if (!found && req[sel]) begin
        found       = 1'b1;
        onehot[sel] = 1'b1;
        idx         = sel;
      end
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write port arbiter: captures one request per even phase, writes it in the odd slot.
// RF_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module reg_write_arbiter import rf_arb_pkg::*; #(
  parameter int W = RF_W,
  parameter int D = RF_D,
  parameter int N = RF_N
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                phase_odd,
  input  logic [N-1:0]        req,
  input  logic [N-1:0][D-1:0] req_addr,
  input  logic [N-1:0][W-1:0] req_data,
  output logic [N-1:0]        gnt,
  output logic                write_en,
  output logic [D-1:0]        waddr,
  output logic [W-1:0]        data_out,
  input  logic [D-1:0]        raddrA,
  input  logic [D-1:0]        raddrB,
  output logic                stall
);

  localparam int IW = idx_width(N);

  arb_state_t    state;
  logic [D-1:0]  hold_addr;
  logic [W-1:0]  hold_data;
  logic [N-1:0]  win_onehot;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] ptr;
  logic          pending;
  logic          capture;
  logic          slot_done;

  assign pending   = (state == ARB_PENDING);
  assign capture   = (state == ARB_IDLE) && !phase_odd && (|req);
  assign slot_done = pending && phase_odd;

  rr_picker #(.N(N), .IW(IW)) u_picker (
    .req    (req),
    .ptr    (ptr),
    .onehot (win_onehot),
    .idx    (win_idx)
  );

`ifdef RF_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [IW-1:0] last_idx;

  // pointer moves only once the granted write has actually used its slot
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr      <= '0;
      last_idx <= '0;
    end else begin
      if (capture) last_idx <= win_idx;
      if (slot_done) ptr <= (last_idx == IW'(N - 1)) ? '0 : last_idx + IW'(1);
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ARB_IDLE;
      hold_addr <= '0;
      hold_data <= '0;
      gnt       <= '0;
    end else begin
      gnt <= '0;
      if (capture) begin
        state     <= ARB_PENDING;
        hold_addr <= req_addr[win_idx];
        hold_data <= req_data[win_idx];
        gnt       <= win_onehot;
      end else if (slot_done) begin
        state <= ARB_IDLE;
      end
    end
  end

  // writes to register 0 consume the slot without touching the file
  assign write_en = slot_done && (hold_addr != '0);
  assign waddr    = hold_addr;
  assign data_out = hold_data;

  assign stall = pending &&
                 (((raddrA != '0) && (raddrA == hold_addr)) ||
                  ((raddrB != '0) && (raddrB == hold_addr)));

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and randomized bench for reg_write_arbiter with a transaction-level reference model.
module tb_reg_write_arbiter;

  localparam int W = 8;
  localparam int D = 4;
  localparam int N = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                phase_odd = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0][D-1:0] req_addr = '0;
  logic [N-1:0][W-1:0] req_data = '0;
  logic [N-1:0]        gnt;
  logic                write_en;
  logic [D-1:0]        waddr;
  logic [W-1:0]        data_out;
  logic [D-1:0]        raddr_a = '0;
  logic [D-1:0]        raddr_b = '0;
  logic                stall;

  int checks = 0;
  int failures = 0;

  // reference model: one outstanding write, who owns it, and where the next search starts
  bit           m_pend = 1'b0;
  int           m_who = 0;
  int           m_next = 0;
  logic [D-1:0] m_addr = '0;
  logic [W-1:0] m_data = '0;
  logic [N-1:0] m_gnt = '0;
  bit           auto_req = 1'b0;
  logic [N-1:0] exp_gnt;

  always #5 clk = ~clk;

  reg_write_arbiter #(.W(W), .D(D), .N(N)) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .phase_odd (phase_odd),
    .req       (req),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gnt       (gnt),
    .write_en  (write_en),
    .waddr     (waddr),
    .data_out  (data_out),
    .raddrA    (raddr_a),
    .raddrB    (raddr_b),
    .stall     (stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_stall();
    return m_pend && (((raddr_a != 0) && (raddr_a == m_addr)) ||
                      ((raddr_b != 0) && (raddr_b == m_addr)));
  endfunction

  task automatic check_outputs();
    chk("gnt", 32'(gnt), 32'(m_gnt));
    chk("write_en", 32'(write_en), 32'(m_pend && phase_odd && (m_addr != 0)));
    chk("waddr", 32'(waddr), 32'(m_addr));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("stall", 32'(stall), 32'(model_stall()));
  endtask

  task automatic model_edge();
    m_gnt = '0;
    if (!m_pend) begin
      if (!phase_odd && (req != 0)) begin
        for (int i = 0; i < N; i++) begin
          int c;
`ifdef RF_ARB_FIXED_PRIO_EN
          c = i;
`else
          c = (m_next + i) % N;
`endif
          if (req[c] && !m_pend) begin
            m_pend   = 1'b1;
            m_who    = c;
            m_addr   = req_addr[c];
            m_data   = req_data[c];
            m_gnt[c] = 1'b1;
          end
        end
      end
    end else if (phase_odd) begin
      m_pend = 1'b0;
      m_next = (m_who + 1) % N;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] seen;
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    seen = m_gnt;
    model_edge();
    #1;
    if (auto_req) begin
      for (int k = 0; k < N; k++) begin
        if (seen[k]) begin
          req[k] = 1'($urandom_range(0, 1));
          req_addr[k] = D'($urandom_range(0, 15));
          req_data[k] = W'($urandom);
        end else if (!req[k] && ($urandom_range(0, 2) == 0)) begin
          req[k] = 1'b1;
          req_addr[k] = D'($urandom_range(0, 15));
          req_data[k] = W'($urandom);
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_we", 32'(write_en), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_waddr", 32'(waddr), 0);
    chk("rst_data", 32'(data_out), 0);
    m_pend = 1'b0;
    m_gnt = '0;
    m_addr = '0;
    m_data = '0;
    m_next = 0;
    m_who = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2;
    apply_reset();
    cycle();

    // single request from the ALU
    phase_odd = 1'b0; req = 3'b001; req_addr[0] = 4'd3; req_data[0] = 8'hA5; raddr_a = 4'd3;
    cycle();
    chk("single_gnt", 32'(gnt), 1);
    chk("single_stall", 32'(stall), 1);
    chk("single_we_even", 32'(write_en), 0);
    phase_odd = 1'b1;
    #1;
    chk("single_we", 32'(write_en), 1);
    chk("single_waddr", 32'(waddr), 3);
    chk("single_data", 32'(data_out), 'hA5);
    cycle();
    req = '0; phase_odd = 1'b0;
    #1;
    chk("single_stall_after", 32'(stall), 0);
    cycle();

    // round-robin with every requester held high
    raddr_a = '0;
    apply_reset();
    req = 3'b111;
    req_addr[0] = 4'd1; req_addr[1] = 4'd2; req_addr[2] = 4'd3;
    req_data[0] = 8'h11; req_data[1] = 8'h22; req_data[2] = 8'h33;
    for (int k = 0; k < 6; k++) begin
      phase_odd = 1'b0;
      cycle();
`ifdef RF_ARB_FIXED_PRIO_EN
      exp_gnt = 3'b001;
`else
      exp_gnt = 3'(1 << (k % 3));
`endif
      chk("rr_gnt", 32'(gnt), 32'(exp_gnt));
      phase_odd = 1'b1;
      #1;
      chk("rr_we", 32'(write_en), 1);
      cycle();
    end

    // extended even phase with a second requester waiting
    req = 3'b011; req_addr[0] = 4'd7; req_data[0] = 8'h3C; req_addr[1] = 4'd4; raddr_b = 4'd7;
    phase_odd = 1'b0;
    cycle();
    chk("ext_gnt", 32'(gnt), 1);
    cycle();
    req[0] = 1'b0;
    repeat (3) begin
      cycle();
      chk("ext_nogrant", 32'(gnt), 0);
      chk("ext_stall", 32'(stall), 1);
      chk("ext_we_even", 32'(write_en), 0);
    end
    phase_odd = 1'b1;
    #1;
    chk("ext_we", 32'(write_en), 1);
    chk("ext_waddr", 32'(waddr), 7);
    chk("ext_stall_write", 32'(stall), 1);
    cycle();
    phase_odd = 1'b0;
    #1;
    chk("ext_stall_clear", 32'(stall), 0);
    cycle();
    chk("ext_next_gnt", 32'(gnt), 2);
    phase_odd = 1'b1;
    cycle();
    req = '0; raddr_b = '0;

    // write to register 0
    req = 3'b100; req_addr[2] = 4'd0; req_data[2] = 8'hFF; raddr_a = '0;
    phase_odd = 1'b0;
    cycle();
    chk("zero_gnt", 32'(gnt), 4);
    chk("zero_stall", 32'(stall), 0);
    phase_odd = 1'b1;
    #1;
    chk("zero_we", 32'(write_en), 0);
    cycle();
    req = '0;

    // request raised in an odd cycle waits for the next even edge
    phase_odd = 1'b1; req = 3'b001; req_addr[0] = 4'd9; req_data[0] = 8'h5A; raddr_a = 4'd9;
    repeat (2) begin
      cycle();
      chk("odd_nogrant", 32'(gnt), 0);
      chk("odd_nostall", 32'(stall), 0);
    end
    phase_odd = 1'b0;
    cycle();
    chk("odd_gnt", 32'(gnt), 1);
    chk("odd_stall", 32'(stall), 1);
    phase_odd = 1'b1;
    cycle();
    req = '0;

    // reset while a write to register 5 is pending
    req = 3'b011; req_addr[0] = 4'd6; req_addr[1] = 4'd5; req_data[1] = 8'h77; raddr_a = 4'd5;
    phase_odd = 1'b0;
    cycle();
    chk("rstw_gnt", 32'(gnt), 2);
    apply_reset();
    phase_odd = 1'b1;
    #1;
    chk("rstw_we", 32'(write_en), 0);
    chk("rstw_stall", 32'(stall), 0);
    chk("rstw_waddr", 32'(waddr), 0);
    cycle();
    req = 3'b111; req_addr[2] = 4'd2;
    phase_odd = 1'b0;
    cycle();
    chk("rstw_first_gnt", 32'(gnt), 1);
    phase_odd = 1'b1;
    cycle();
    req = '0; raddr_a = '0;

    // randomized traffic with protocol-following requesters
    auto_req = 1'b1;
    repeat (400) begin
      phase_odd = 1'($urandom_range(0, 1));
      raddr_a = ($urandom_range(0, 1) == 1) ? m_addr : D'($urandom_range(0, 15));
      raddr_b = ($urandom_range(0, 1) == 1) ? m_addr : D'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) apply_reset();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
